// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter/sequencer.
//   op_e    : ALU opcodes. Every opcode with op[2]=1 is handled as a multiply.
//   state_e : sequencer states.
//   is_nop  : flags an opcode that completes without using the ALU.
package alu_ctrl_pkg;

    localparam int RES_W  = 16;
    localparam int OPND_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [2:0] {
        NOP = 3'b000,
        ADD = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return (op == 3'b000);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Command/response bundle between the requesters and the ALU arbiter.
//   req_valid/req_ready : per-requester command handshake (ready is one-hot or zero)
//   req_a/req_b/req_op  : packed per-requester payload, slice i belongs to requester i
//   resp_*              : single shared response channel tagged with the requester id
// modport slave is the arbiter's view; modport master is the requester side.
interface alu_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    logic [8*NREQ-1:0]            req_a;
    logic [8*NREQ-1:0]            req_b;
    logic [3*NREQ-1:0]            req_op;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [$clog2(NREQ)-1:0]      resp_id;
    logic [15:0]                  resp_result;
    logic                         resp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_err
    );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : request vector
//   enable       : arbitration allowed this cycle
//   grant        : one-hot grant (zero when disabled or no request)
//   idx          : index of the winning requester (valid when grant != 0)
// Search starts at pointer+1; the pointer moves to the winner only when a
// grant is actually issued. Reset puts the pointer at N-1 so requester 0
// has top priority first.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] pick_s;
    logic          found_s;
    int            cand_s;

    // Rotating priority search beginning just after the last winner.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = 0;
        grant   = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = (int'(ptr_r) + i) % N;
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = IW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        if (enable && found_s) begin
            grant[pick_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign idx = pick_s;

    // Pointer follows the most recent issued grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r <= IW'(N - 1);
        end else if (enable && found_s) begin
            ptr_r <= pick_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one tinyalu-style ALU between NREQ requesters.
//   clk, reset_n     : clock, synchronous active-low reset (shared with the ALU)
//   bus (slave)      : per-requester commands in, tagged response out
//   alu_a/b/op       : operands, held from grant until the response is accepted
//   alu_start        : one-cycle start pulse
//   alu_done         : ALU completion strobe, alu_result valid with it
//   busy             : sequencer not idle
// Flow: IDLE (grant + capture) -> ISSUE (start pulse) -> WAIT (done or
// timeout) -> RESP (hold until resp_ready). NOP skips straight to RESP
// because the ALU never answers it.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_arbiter_if.slave      bus,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_e             state_r;
    state_e             state_next_s;
    logic [NREQ-1:0]    grant_s;
    logic [IW-1:0]      idx_s;
    logic               any_grant_s;
    logic               arb_en_s;
    logic               timeout_s;
    logic [OPND_W-1:0]  a_sel_s;
    logic [OPND_W-1:0]  b_sel_s;
    logic [OP_W-1:0]    op_sel_s;

    logic [OPND_W-1:0]  alu_a_r;
    logic [OPND_W-1:0]  alu_b_r;
    logic [OP_W-1:0]    alu_op_r;
    logic               alu_start_r;
    logic               busy_r;
    logic               resp_valid_r;
    logic [IW-1:0]      resp_id_r;
    logic [RES_W-1:0]   resp_result_r;
    logic               resp_err_r;
    logic [TW-1:0]      timer_r;

    // Arbitration only happens in IDLE, so req_ready is zero while busy.
    assign arb_en_s = (state_r == IDLE);

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .enable  (arb_en_s),
        .grant   (grant_s),
        .idx     (idx_s)
    );

    assign any_grant_s   = |grant_s;
    assign bus.req_ready = grant_s;
    assign a_sel_s       = bus.req_a[idx_s*OPND_W +: OPND_W];
    assign b_sel_s       = bus.req_b[idx_s*OPND_W +: OPND_W];
    assign op_sel_s      = bus.req_op[idx_s*OP_W +: OP_W];
    assign timeout_s     = (timer_r == TW'(TIMEOUT - 1));

    // Next-state decode of the sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_grant_s) begin
                    if (is_nop(op_sel_s)) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (alu_done || timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, operand, timer and response registers. Strobes are derived from
    // the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_op_r      <= '0;
            alu_start_r   <= 1'b0;
            busy_r        <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= '0;
            resp_result_r <= '0;
            resp_err_r    <= 1'b0;
            timer_r       <= '0;
        end else begin
            state_r      <= state_next_s;
            alu_start_r  <= (state_next_s == ISSUE);
            busy_r       <= (state_next_s != IDLE);
            resp_valid_r <= (state_next_s == RESP);
            case (state_r)
                IDLE: begin
                    if (any_grant_s) begin
                        alu_a_r   <= a_sel_s;
                        alu_b_r   <= b_sel_s;
                        alu_op_r  <= op_sel_s;
                        resp_id_r <= idx_s;
                        if (is_nop(op_sel_s)) begin
                            resp_result_r <= '0;
                            resp_err_r    <= 1'b0;
                        end
                    end
                end
                ISSUE: timer_r <= '0;
                WAIT: begin
                    timer_r <= timer_r + TW'(1);
                    if (alu_done) begin
                        resp_result_r <= alu_result;
                        resp_err_r    <= 1'b0;
                    end else if (timeout_s) begin
                        resp_result_r <= '0;
                        resp_err_r    <= 1'b1;
                    end
                end
                RESP: timer_r <= timer_r;
                default: timer_r <= '0;
            endcase
        end
    end

    assign alu_a           = alu_a_r;
    assign alu_b           = alu_b_r;
    assign alu_op          = alu_op_r;
    assign alu_start       = alu_start_r;
    assign busy            = busy_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_id     = resp_id_r;
    assign bus.resp_result = resp_result_r;
    assign bus.resp_err    = resp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard of expected responses pushed on
// each command handshake and popped on each response handshake.
module tb_alu_arbiter;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, alu_done, busy;
    logic [15:0] alu_result;

    int   n_cmp = 0, n_mis = 0;
    int   cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0, resp_seen = 0;
    logic in_op = 1'b0, stab_bad = 1'b0, resp_prev = 1'b0, alu_hang = 1'b0;
    logic [7:0]  sa, sbv;
    logic [2:0]  so;
    int          alu_cnt = 0;
    logic [15:0] alu_res_q = 16'h0000;
    int   more[4];
    int   nxt[4];
    int   grant_q[$];
    exp_t sb[$];

    alu_arbiter_if #(.NREQ(4)) bus ();

    alu_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (op[2]) return 16'(a) * 16'(b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: done 1 cycle after start, 4 cycles for op[2]=1; can hang.
    always @(posedge clk) begin
        if (!reset_n) begin
            alu_cnt <= 0;
        end else if (alu_start) begin
            alu_res_q <= model(alu_a, alu_b, alu_op);
            alu_cnt   <= alu_op[2] ? 4 : 1;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
        end
    end
    assign alu_done   = (alu_cnt == 1) && !alu_hang;
    assign alu_result = alu_res_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: start pulses, operand stability, response rise and scoreboard pops.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_op     = 1'b0;
            resp_prev = 1'b0;
        end else begin
            if (alu_start) begin
                start_cnt++;
                start_cyc = cyc;
                sa = alu_a; sbv = alu_b; so = alu_op;
                in_op = 1'b1;
            end else if (in_op) begin
                if ({alu_a, alu_b, alu_op} != {sa, sbv, so}) stab_bad = 1'b1;
                if (bus.resp_valid) in_op = 1'b0;
            end
            if (bus.resp_valid && !resp_prev) rise_cyc = cyc;
            resp_prev = bus.resp_valid;
            if (bus.resp_valid && bus.resp_ready) begin
                resp_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_result", 32'(bus.resp_result), 32'(e.res));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                end
            end
        end
    end

    function automatic logic [7:0] gen_a(input int i, input int k);
        return 8'(16 * i + k + 1);
    endfunction
    function automatic logic [7:0] gen_b(input int i, input int k);
        return 8'(7 * k + i);
    endfunction

    task automatic load_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req_a[i*8 +: 8]  = a;
        bus.req_b[i*8 +: 8]  = b;
        bus.req_op[i*3 +: 3] = op;
        bus.req_valid[i]     = 1'b1;
    endtask

    // One clock: note handshakes (push expectations), then reload or drop requesters.
    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                exp_t e;
                e.id  = i;
                e.res = alu_hang ? 16'h0000 : model(bus.req_a[i*8 +: 8], bus.req_b[i*8 +: 8], bus.req_op[i*3 +: 3]);
                e.err = alu_hang;
                sb.push_back(e);
                grant_q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (more[i] > 0) begin
                    more[i]--;
                    nxt[i]++;
                    load_req(i, gen_a(i, nxt[i]), gen_b(i, nxt[i]), 3'b001);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k;
        k = 0;
        while (resp_seen < n && k < budget) begin
            step();
            k++;
        end
        chk("resp_wait", 32'(resp_seen >= n), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_rready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_start"},  32'(alu_start), 32'd0);
        chk({tag, "_alu"},    32'({alu_a, alu_b, alu_op}), 32'd0);
        chk({tag, "_resp"},   32'({bus.resp_id, bus.resp_result, bus.resp_err}), 32'd0);
    endtask

    initial begin
        int base, sc;
        logic [31:0] held;
        for (int i = 0; i < 4; i++) begin
            more[i] = 0;
            nxt[i]  = 0;
        end
        bus.req_valid  = 4'b0000;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.req_op     = 12'h0;
        bus.resp_ready = 1'b1;
        reset_n        = 1'b0;
        repeat (3) step();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // ADD from requester 0 after reset: one start pulse, done next cycle.
        sc = start_cnt; base = resp_seen;
        load_req(0, 8'h12, 8'h34, 3'b001);
        wait_resp(base + 1, 20);
        chk("add_starts", 32'(start_cnt - sc), 32'd1);
        chk("add_latency", 32'(rise_cyc - start_cyc), 32'd2);
        chk("add_value", 32'(model(8'h12, 8'h34, 3'b001)), 32'h0046);

        // MUL from requester 2: operands held through the 4-cycle wait.
        stab_bad = 1'b0; sc = start_cnt; base = resp_seen;
        load_req(2, 8'hFF, 8'hFF, 3'b100);
        wait_resp(base + 1, 20);
        chk("mul_starts", 32'(start_cnt - sc), 32'd1);
        chk("mul_latency", 32'(rise_cyc - start_cyc), 32'd5);
        chk("mul_stable", 32'(stab_bad), 32'd0);
        chk("mul_value", 32'(model(8'hFF, 8'hFF, 3'b100)), 32'h0000FE01);

        // XOR from requester 3.
        base = resp_seen;
        load_req(3, 8'hF0, 8'h3C, 3'b011);
        wait_resp(base + 1, 20);

        // NOP from requester 1: zero result, ALU never started.
        sc = start_cnt; base = resp_seen;
        load_req(1, 8'h05, 8'h06, 3'b000);
        wait_resp(base + 1, 20);
        chk("nop_no_start", 32'(start_cnt - sc), 32'd0);

        // Response back-pressure with a second requester waiting.
        bus.resp_ready = 1'b0; base = resp_seen;
        load_req(2, 8'h20, 8'h22, 3'b001);
        load_req(0, 8'h01, 8'h01, 3'b001);
        for (int k = 0; k < 20 && !bus.resp_valid; k++) step();
        chk("stall_valid", 32'(bus.resp_valid), 32'd1);
        held = {12'h0, 1'b0, bus.resp_id, bus.resp_result, bus.resp_err};
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_hold", {12'h0, bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_err}, held | 32'h0008_0000);
            chk("stall_no_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        wait_resp(base + 2, 30);
        chk("stall_next_grant", 32'(grant_q[grant_q.size() - 1]), 32'd0);

        // ALU never answers: timeout raised once the wait timer reaches TIMEOUT-1
        // (8 cycles after start), response on the following cycle.
        alu_hang = 1'b1; base = resp_seen;
        load_req(3, 8'h01, 8'h02, 3'b001);
        wait_resp(base + 1, 30);
        chk("timeout_latency", 32'(rise_cyc - start_cyc), 32'd9);
        alu_hang = 1'b0;
        step();

        // Reset during WAIT: everything back to reset values, no response.
        sc = start_cnt; base = resp_seen;
        load_req(0, 8'h11, 8'h22, 3'b100);
        for (int k = 0; k < 10 && start_cnt == sc; k++) step();
        chk("rst_started", 32'(start_cnt - sc), 32'd1);
        reset_n = 1'b0;
        sb.delete();
        step();
        chk_reset_vals("midrst");
        reset_n = 1'b1;
        repeat (12) step();
        chk("midrst_no_resp", 32'(resp_seen - base), 32'd0);

        // All four requesters valid continuously: strict rotation from 0.
        grant_q.delete(); base = resp_seen;
        for (int i = 0; i < 4; i++) begin
            more[i] = 1;
            nxt[i]  = 0;
            load_req(i, gen_a(i, 0), gen_b(i, 0), 3'b001);
        end
        wait_resp(base + 8, 80);
        chk("rr_count", 32'(grant_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_q.size(); k++) chk("rr_order", 32'(grant_q[k]), 32'(k % 4));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one tinyalu-style ALU between NREQ requesters.
- Each requester presents {A, B, op} on a valid/ready channel.
- The block grants one requester, pulses the ALU start for one cycle and holds operands stable until done.
- It returns the 16-bit result tagged with the requester id on a single valid/ready response channel. Sits between the command fabric and the ALU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles from alu_start to alu_done before the op is aborted with error.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  8*NREQ  operand A, slice i belongs to requester i
- req_b  in  8*NREQ  operand B
- req_op  in  3*NREQ  opcode
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  $clog2(NREQ)  requester index of the response
- resp_result  out  16  ALU result
- resp_err  out  1  timeout occurred
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_op  out  3  ALU opcode
- alu_start  out  1  ALU start pulse
- alu_done  in  1  ALU done
- alu_result  in  16  ALU result
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, alu_a/b/op=0, alu_start=0, busy=0, timer=0, rr pointer=NREQ-1 (so requester 0 wins first).
- Reset mid-operation: all state is dropped and the block returns to IDLE next edge; the ALU shares reset_n. No response is issued for the aborted op.
- IDLE:
  - If any req_valid, pick the winner by round-robin starting at pointer+1.
  - req_ready[winner]=1 combinationally this cycle; registers operands into alu_a/b/op and id.
  - Pointer becomes winner.
  - If op==NOP(000): go to RESP with result=0, err=0, no ALU start. The ALU never signals done for NOP.
  - Otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT:
  - alu_start=0; alu_a/b/op held constant; timer increments.
  - On alu_done=1: capture alu_result, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: result=0, err=1, go to RESP.
  - Expected timing: done 1 cycle after start for op 001..011; 4 cycles after start for op[2]=1 (ops 100..111, all treated as multiply by the ALU).
- RESP:
  - resp_valid=1; id/result/err held stable until resp_ready.
  - On the handshake go to IDLE; next grant no earlier than the following cycle.
  - No req_ready while busy; one op in flight at a time.
- Throughput: ADD ≈ 4 cycles per op with resp_ready=1 (IDLE, ISSUE, WAIT, RESP); MUL ≈ 7 cycles.
- req_ready is 0 for every non-winner and in every non-IDLE state.
- Requesters must hold valid and payload until ready (AXI-style). The arbiter does not require this for correctness, since it samples only on the handshake.
- A requester deasserting valid before grant is simply skipped.

Decomposition:
- Package alu_ctrl_pkg:
  - op enum: NOP=3'b000, ADD=3'b001, AND=3'b010, XOR=3'b011, MUL=3'b100.
  - state enum: IDLE, ISSUE, WAIT, RESP.
  - RES_W=16, OPND_W=8.
- Sub-module rr_arbiter (param N): inputs req vector and enable; outputs one-hot grant and index; owns the rotating pointer, which updates only when enable and a grant occur.

Test Plan:
- After reset, req0 ADD A=8'h12 B=8'h34 -> one-cycle alu_start, resp_id=0, resp_result=16'h0046, resp_err=0.
- req2 MUL A=8'hFF B=8'hFF -> alu_start one cycle, alu_a/b stable 4+ cycles, resp_result=16'hFE01; XOR 8'hF0^8'h3C -> 16'h00CC.
- All 4 requesters valid continuously with distinct ADD ops -> grants 0,1,2,3,0,...; each resp_id matches; no requester starved.
- req1 op=NOP -> resp_result=0, resp_err=0, alu_start never asserted.
- resp_ready held low 5 cycles during RESP -> resp_* stable, req_ready all 0; after release the next grant proceeds.
- ALU model with alu_done tied 0, TIMEOUT=8 -> resp_err=1, resp_result=0, 8 cycles after start. Separately, assert reset_n=0 during WAIT -> all outputs at reset values next cycle, and the pending op produces no response.
